// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-count receive checker.
// Also hosts the generic Gray-to-binary decode function.
package gray_pkg;

  localparam int GRAY_CBITS_DEFAULT = 18;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } gray_rx_state_t;

  // Callers zero-extend narrower counts; upper zeros leave low bits intact.
  function automatic logic [63:0] gray2bin(input logic [63:0] g);
    logic [63:0] b;
    b[63] = g[63];
    for (int i = 62; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_rx_checker_gray_to_bin.sv
// Combinational W-bit Gray-to-binary decoder (W up to 64).
// Thin wrapper around gray_pkg::gray2bin.
module gray_to_bin
  import gray_pkg::*;
#(
  parameter int W = GRAY_CBITS_DEFAULT
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(64'(gray)));

endmodule

// File: rtl/gray_rx_checker.sv
// Gray-count receive checker: decode, +1 check, lock tracking, wrap/err pulses.
// Optional saturating error counter enabled by GRAY_RX_ERRCNT_EN.
module gray_rx_checker
  import gray_pkg::*;
#(
  parameter int CBITS    = GRAY_CBITS_DEFAULT,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CBITS-1:0] gray_in,
  input  logic             gray_valid,
  output logic [CBITS-1:0] bin_out,
  output logic             bin_valid,
  output logic             wrap,
  output logic             err,
  output logic             locked
`ifdef GRAY_RX_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  gray_rx_state_t   state;
  logic [CBITS-1:0] dec;
  logic [CBITS-1:0] prev;
  logic [3:0]       good_cnt;
  logic             inc_ok;
  logic             is_zero;

  gray_to_bin #(.W(CBITS)) u_dec (
    .gray (gray_in),
    .bin  (dec)
  );

  // Sum truncates to CBITS, so all-ones followed by zero is a good step.
  assign inc_ok  = (dec == prev + CBITS'(1));
  assign is_zero = (dec == '0);
  assign locked  = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= UNLOCKED;
      prev      <= '0;
      good_cnt  <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      bin_valid <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      if (gray_valid) begin
        bin_out   <= dec;
        bin_valid <= 1'b1;
        prev      <= dec;
        case (state)
          UNLOCKED: begin
            good_cnt <= '0;
            state    <= ACQUIRE;
          end
          ACQUIRE: begin
            if (inc_ok) begin
              wrap     <= is_zero;
              good_cnt <= good_cnt + 4'd1;
              if (good_cnt + 4'd1 == LOCK_N) state <= LOCKED;
            end else begin
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (inc_ok) begin
              wrap <= is_zero;
            end else begin
              err      <= 1'b1;
              good_cnt <= '0;
              state    <= ACQUIRE;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

`ifdef GRAY_RX_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (gray_valid && state == LOCKED && !inc_ok) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
